// File: rtl/seq_gen_10010_if.sv
// Load handshake and serial output bundle for seq_gen_10010.
// The transmitter uses the slave modport; the driver/checker side uses the master modport.
interface seq_gen_10010_if #(
  parameter int unsigned DW = 24
);
  logic [DW-1:0] load_data;
  logic          load_valid;
  logic          load_ready;
  logic          mode_loop;
  logic          stop;
  logic          dout;
  logic          dout_valid;
  logic          busy;
  logic          frame_done;
  logic          exp_hit;
  logic [7:0]    hit_cnt;

  modport slave (
    input  load_data, load_valid, mode_loop, stop,
    output load_ready, dout, dout_valid, busy, frame_done, exp_hit, hit_cnt
  );

  modport master (
    output load_data, load_valid, mode_loop, stop,
    input  load_ready, dout, dout_valid, busy, frame_done, exp_hit, hit_cnt
  );
endinterface

// File: rtl/seq_gen_10010.sv
// Serial MSB-first frame transmitter with single/loop modes and a golden
// PAT matcher on its own output stream (exp_hit / hit_cnt).
module seq_gen_10010 #(
  parameter int unsigned     DW   = 24,
  parameter int unsigned     PLEN = 5,
  parameter logic [PLEN-1:0] PAT  = 5'b10010
) (
  input  logic            clk,
  input  logic            rst,
  seq_gen_10010_if.slave  bus
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e          state_q;
  logic [DW-1:0]   shreg_q;
  logic [DW-1:0]   shreg_d;
  logic [CW-1:0]   bitcnt_q;
  logic [PLEN-2:0] hist_q;
  logic            loop_q;
  logic            stop_pend_q;
  logic            dout_q;
  logic            dout_valid_q;
  logic            frame_done_q;
  logic            exp_hit_q;
  logic [7:0]      hit_cnt_q;
  logic [7:0]      hit_cnt_d;

  logic            msb;
  logic [PLEN-1:0] window;
  logic            match;
  logic            last_bit;
  logic            keep_looping;

  // The matcher window includes the bit being emitted this edge, so exp_hit
  // lands in the same cycle as the completing dout bit.
  always_comb begin
    msb          = shreg_q[DW-1];
    shreg_d      = {shreg_q[DW-2:0], shreg_q[DW-1]};
    window       = {hist_q, msb};
    match        = (window == PAT);
    last_bit     = (bitcnt_q == CW'(DW - 1));
    keep_looping = loop_q & ~stop_pend_q & ~bus.stop;
    hit_cnt_d    = hit_cnt_q;
    if (match && (hit_cnt_q != 8'hFF)) begin
      hit_cnt_d = hit_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      hist_q       <= '0;
      loop_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      exp_hit_q    <= 1'b0;
      hit_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          dout_q       <= 1'b0;
          dout_valid_q <= 1'b0;
          exp_hit_q    <= 1'b0;
          frame_done_q <= 1'b0;
          if (bus.load_valid) begin
            shreg_q     <= bus.load_data;
            loop_q      <= bus.mode_loop;
            bitcnt_q    <= '0;
            hist_q      <= '0;
            hit_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            state_q     <= SHIFT;
          end
        end

        SHIFT: begin
          dout_q       <= msb;
          dout_valid_q <= 1'b1;
          shreg_q      <= shreg_d;
          hist_q       <= window[PLEN-2:0];
          bitcnt_q     <= bitcnt_q + CW'(1);
          exp_hit_q    <= match;
          hit_cnt_q    <= hit_cnt_d;
          frame_done_q <= last_bit;
          if (bus.stop) begin
            stop_pend_q <= 1'b1;
          end
          // hist is deliberately kept across a loop wrap so patterns spanning
          // the frame boundary are still counted.
          if (last_bit) begin
            if (keep_looping) begin
              bitcnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.exp_hit    = exp_hit_q;
  assign bus.hit_cnt    = hit_cnt_q;

endmodule

// File: tb/tb_seq_gen_10010.sv
// Self-checking bench for seq_gen_10010: reset vector table, then frame
// transactions whose expected per-cycle outputs are queued and compared.
module tb_seq_gen_10010;

  localparam int unsigned     DW   = 24;
  localparam int unsigned     PLEN = 5;
  localparam logic [PLEN-1:0] PAT  = 5'b10010;

  typedef struct packed {
    logic       load_ready;
    logic       busy;
    logic       dout_valid;
    logic       dout;
    logic       frame_done;
    logic       exp_hit;
    logic [7:0] hit_cnt;
  } out_t;

  typedef struct {
    logic          rst;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          mode_loop;
    logic          stop;
    out_t          exp;
  } vec_t;

  logic clk;
  logic rst;

  seq_gen_10010_if #(.DW(DW)) bus ();

  seq_gen_10010 #(.DW(DW), .PLEN(PLEN), .PAT(PAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t       exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_hc      = '0;

  function automatic out_t o_reset();
    out_t o;
    o = '{load_ready: 1'b1, busy: 1'b0, dout_valid: 1'b0, dout: 1'b0,
          frame_done: 1'b0, exp_hit: 1'b0, hit_cnt: 8'd0};
    return o;
  endfunction

  function automatic out_t o_idle(input logic [7:0] hc);
    out_t o;
    o = o_reset();
    o.hit_cnt = hc;
    return o;
  endfunction

  task automatic drive(input logic r, input logic lv, input logic [DW-1:0] d,
                       input logic ml, input logic st);
    rst            = r;
    bus.load_valid = lv;
    bus.load_data  = d;
    bus.mode_loop  = ml;
    bus.stop       = st;
  endtask

  task automatic check(input string name, input int idx);
    out_t got;
    out_t want;
    @(posedge clk);
    #1;
    got.load_ready = bus.load_ready;
    got.busy       = bus.busy;
    got.dout_valid = bus.dout_valid;
    got.dout       = bus.dout;
    got.frame_done = bus.frame_done;
    got.exp_hit    = bus.exp_hit;
    got.hit_cnt    = bus.hit_cnt;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s[%0d]: scoreboard empty, got %h", name, idx, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s[%0d]: got rdy=%b busy=%b dv=%b dout=%b fd=%b hit=%b hc=%0d, want rdy=%b busy=%b dv=%b dout=%b fd=%b hit=%b hc=%0d",
                 name, idx, got.load_ready, got.busy, got.dout_valid, got.dout,
                 got.frame_done, got.exp_hit, got.hit_cnt,
                 want.load_ready, want.busy, want.dout_valid, want.dout,
                 want.frame_done, want.exp_hit, want.hit_cnt);
      end
    end
  endtask

  task automatic step(input logic r, input logic lv, input logic [DW-1:0] d,
                      input logic ml, input logic st, input out_t e,
                      input string name, input int idx);
    drive(r, lv, d, ml, st);
    exp_q.push_back(e);
    check(name, idx);
  endtask

  task automatic idle(input string name, input logic st);
    step(1'b0, 1'b0, DW'($urandom), 1'($urandom), st, o_idle(exp_hc), name, -1);
  endtask

  // Expected stream: the word repeated for npass passes MSB-first, hits found
  // by sliding a PLEN-bit window over everything emitted since the load.
  task automatic run_tx(input string name, input logic [DW-1:0] w, input logic loop,
                        input int stop_k, input int abort_k, input logic hold_valid);
    int          npass;
    int          len;
    logic [PLEN-1:0] win;
    logic        b;
    out_t        e;
    npass  = (loop && stop_k >= 0) ? (stop_k / DW + 1) : 1;
    len    = npass * DW;
    win    = '0;
    exp_hc = '0;
    e = '{load_ready: 1'b0, busy: 1'b1, dout_valid: 1'b0, dout: 1'b0,
          frame_done: 1'b0, exp_hit: 1'b0, hit_cnt: 8'd0};
    step(1'b0, 1'b1, w, loop, 1'b0, e, name, -1);
    for (int k = 0; k < len; k++) begin
      if (k == abort_k) begin
        exp_hc = '0;
        step(1'b1, hold_valid, ~w, ~loop, 1'b0, o_reset(), name, k);
        return;
      end
      b   = w[DW-1-(k % DW)];
      win = {win[PLEN-2:0], b};
      e.exp_hit    = (k >= int'(PLEN) - 1) && (win == PAT);
      if (e.exp_hit && exp_hc != 8'hFF) exp_hc = exp_hc + 8'd1;
      e.dout       = b;
      e.dout_valid = 1'b1;
      e.frame_done = ((k % DW) == DW - 1);
      e.busy       = (k != len - 1);
      e.load_ready = (k == len - 1);
      e.hit_cnt    = exp_hc;
      step(1'b0, hold_valid, ~w, ~loop, (k == stop_k), e, name, k);
    end
  endtask

  initial begin
    #(10 * 20000);
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    for (int unsigned i = 0; i < 5; i++) begin
      tbl[i] = '{rst: 1'b1, load_valid: 1'b1, load_data: 24'hC90940,
                 mode_loop: 1'b1, stop: 1'b1, exp: o_reset()};
    end
    for (int unsigned i = 5; i < 7; i++) begin
      tbl[i] = '{rst: 1'b0, load_valid: 1'b0, load_data: 24'hFFFFFF,
                 mode_loop: 1'b1, stop: 1'b1, exp: o_idle(8'd0)};
    end

    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].rst, tbl[i].load_valid, tbl[i].load_data, tbl[i].mode_loop,
           tbl[i].stop, tbl[i].exp, "reset_tbl", i);
    end

    // Single frame with load_valid held high throughout, then back-to-back
    run_tx("single_hold", 24'hC90940, 1'b0, -1, -1, 1'b1);
    run_tx("b2b", 24'hA5A5A5, 1'b0, -1, -1, 1'b0);
    idle("idle_stop", 1'b1);
    idle("idle", 1'b0);

    run_tx("loop_stop_p2", 24'hC90940, 1'b1, 30, -1, 1'b0);
    idle("idle", 1'b0);
    run_tx("loop_stop_last", 24'h000012, 1'b1, 47, -1, 1'b0);
    idle("idle", 1'b0);
    run_tx("loop_wrap_900000", 24'h900000, 1'b1, 24, -1, 1'b0);
    idle("idle", 1'b0);
    run_tx("single_stop", 24'h912490, 1'b0, 5, -1, 1'b0);
    idle("idle", 1'b0);
    run_tx("loop_stop_p1_last", 24'hC90940, 1'b1, 23, -1, 1'b0);
    idle("idle", 1'b0);

    // Abort at bit 10, then a fresh frame
    run_tx("abort", 24'hC90940, 1'b1, -1, 10, 1'b1);
    idle("post_abort", 1'b0);
    run_tx("after_abort", 24'hC90940, 1'b0, -1, -1, 1'b0);
    idle("idle", 1'b0);

    // 100100... repeats cleanly across the wrap: 7 + 8 per pass, saturates
    run_tx("saturate", 24'h924924, 1'b1, 33 * 24 + 5, -1, 1'b0);
    idle("idle_sat", 1'b0);

    for (int i = 0; i < 4; i++) begin
      run_tx("random", DW'($urandom), 1'b0, -1, -1, 1'($urandom));
      if (i[0]) idle("idle", 1'b0);
    end
    idle("idle_end", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
